// File: rtl/entropy_sampler_pkg.sv
// Shared types and width helpers for the entropy sampler and its pair filter.
package entropy_pkg;

  typedef enum logic {
    PAIR_A = 1'b0,
    PAIR_B = 1'b1
  } pair_state_e;

  // Bit counter must be able to hold the value WIDTH itself (word full).
  function automatic int unsigned calc_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned calc_rep_w(input int unsigned rep_limit);
    return $clog2(rep_limit + 1);
  endfunction

endpackage

// File: rtl/entropy_sampler_vn_debiaser.sv
// Von Neumann pair filter: turns unequal synced bit pairs into one accepted bit.
module vn_debiaser
  import entropy_pkg::*;
#(
  parameter int unsigned DEBIAS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic s,
  input  logic clear,
  output logic acc_valid,
  output logic acc_bit
);

  pair_state_e state_q, state_d;
  logic        a_q, a_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAIR_A;
      a_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
    end
  end

  // With filtering off, every stepped bit passes straight through.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    acc_valid = 1'b0;
    acc_bit   = (DEBIAS != 0) ? a_q : s;
    if (clear) begin
      state_d = PAIR_A;
    end else if (step) begin
      if (DEBIAS == 0) begin
        acc_valid = 1'b1;
      end else begin
        case (state_q)
          PAIR_A: begin
            a_d     = s;
            state_d = PAIR_B;
          end
          PAIR_B: begin
            acc_valid = (a_q != s);
            state_d   = PAIR_A;
          end
          default: state_d = PAIR_A;
        endcase
      end
    end
  end

endmodule

// File: rtl/entropy_sampler.sv
// Raw noise bit -> synchroniser -> repetition health check -> pair filter -> word packer
// -> one-entry valid/ready output register.
module entropy_sampler
  import entropy_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned REP_LIMIT   = 16,
  parameter int unsigned DEBIAS      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_i,
  input  logic             en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail
);

  localparam int unsigned CNT_W = calc_cnt_w(WIDTH);
  localparam int unsigned REP_W = calc_rep_w(REP_LIMIT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   prev_s_q, prev_s_d;
  logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
  logic                   health_fail_q, health_fail_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   step, full, out_free;
  logic                   acc_valid, acc_bit;

  assign s        = sync_q[SYNC_STAGES-1];
  assign step     = en & ~health_fail_q;
  assign full     = (bit_cnt_q == CNT_W'(WIDTH));
  assign out_free = ~out_valid_q | out_ready;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};

  // Repetition count; rep_cnt_q==0 only in the first cycle after reset.
  always_comb begin
    prev_s_d  = s;
    rep_cnt_d = REP_W'(1);
    if ((rep_cnt_q != '0) && (s == prev_s_q)) begin
      rep_cnt_d = (rep_cnt_q == {REP_W{1'b1}}) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
    end
    health_fail_d = health_fail_q | (rep_cnt_d >= REP_W'(REP_LIMIT));
  end

  vn_debiaser #(
    .DEBIAS(DEBIAS)
  ) u_vn_debiaser (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .s        (s),
    .clear    (~en),
    .acc_valid(acc_valid),
    .acc_bit  (acc_bit)
  );

  // A full word waits in shreg until the output register frees; bits arriving meanwhile are lost.
  always_comb begin
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (full && out_free && !health_fail_q) begin
      out_data_d  = shreg_q;
      out_valid_d = 1'b1;
      bit_cnt_d   = '0;
    end else if (acc_valid && !full) begin
      shreg_d   = {shreg_q[WIDTH-2:0], acc_bit};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    if (!en) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      prev_s_q      <= 1'b0;
      rep_cnt_q     <= '0;
      health_fail_q <= 1'b0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      prev_s_q      <= prev_s_d;
      rep_cnt_q     <= rep_cnt_d;
      health_fail_q <= health_fail_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_entropy_sampler.sv
// Directed bench: dut0 runs without pair filtering, dut1 with it; both share stimulus.
module tb_entropy_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw_i;
  logic       en;
  logic       out_ready;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       hf0, hf1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  entropy_sampler #(.SYNC_STAGES(2), .WIDTH(8), .REP_LIMIT(16), .DEBIAS(0)) dut0 (
    .clk(clk), .rst(rst), .raw_i(raw_i), .en(en), .out_data(data0),
    .out_valid(valid0), .out_ready(out_ready), .health_fail(hf0)
  );

  entropy_sampler #(.SYNC_STAGES(2), .WIDTH(8), .REP_LIMIT(16), .DEBIAS(1)) dut1 (
    .clk(clk), .rst(rst), .raw_i(raw_i), .en(en), .out_data(data1),
    .out_valid(valid1), .out_ready(out_ready), .health_fail(hf1)
  );

  typedef struct packed {
    logic       raw;
    logic       en;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [0:12];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      raw_i = ~raw_i;
      cyc();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  // First bit = bits[n-1]; en rises exactly when that bit reaches the synced output.
  task automatic stream(input logic [63:0] bits, input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) raw_i = bits[n-1-i];
      else       raw_i = ~raw_i;
      en = (i >= 2);
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    raw_i = 1'b0;
    en = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hB2};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hB2};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hB2};

    // Reset state
    do_reset();
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_data0", 32'(data0), 32'd0);
    check("rst_hf0", 32'(hf0), 32'd0);
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_data1", 32'(data1), 32'd0);

    // Plain packing, one word 0xB2, valid for exactly one cycle
    for (int i = 0; i < 13; i++) begin
      raw_i = tbl[i].raw;
      en = tbl[i].en;
      out_ready = tbl[i].rdy;
      cyc();
      check($sformatf("t1_valid[%0d]", i), 32'(valid0), 32'(tbl[i].exp_valid));
      check($sformatf("t1_data[%0d]", i), 32'(data0), 32'(tbl[i].exp_data));
    end

    // Von Neumann filtering: word 0x66
    do_reset();
    stream(64'(22'b0110001110010110100110), 22);
    en = 1'b0;
    check("t2_valid", 32'(valid1), 32'd1);
    check("t2_data", 32'(data1), 32'h66);

    // Equal pairs only: nothing accepted
    do_reset();
    stream(64'(32'h33333333), 32);
    en = 1'b0;
    idle(2);
    check("t2b_no_word", 32'(valid1), 32'd0);

    // Back-pressure: word 1 held, word 2 waits, word 3 dropped
    do_reset();
    stream(64'(48'h9966_5AA5_AAAA), 48);
    check("t3_valid", 32'(valid1), 32'd1);
    check("t3_data", 32'(data1), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check($sformatf("t3_hold[%0d]", i), 32'(data1), 32'hA5);
    end
    out_ready = 1'b1;
    idle(1);
    check("t3_b2b_valid", 32'(valid1), 32'd1);
    check("t3_b2b_data", 32'(data1), 32'h3C);
    idle(1);
    check("t3_drain_valid", 32'(valid1), 32'd0);
    out_ready = 1'b0;
    en = 1'b0;

    // Health: stuck-at-1 trips on the 16th identical synced bit
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      raw_i = 1'b1;
      cyc();
      check($sformatf("t4_hf[%0d]", k), 32'(hf0), (k >= 17) ? 32'd1 : 32'd0);
    end
    check("t4_hf1", 32'(hf1), 32'd1);
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      idle(1);
      check($sformatf("t4_noload0[%0d]", i), 32'(valid0), 32'd0);
      check($sformatf("t4_noload1[%0d]", i), 32'(valid1), 32'd0);
    end
    check("t4_sticky", 32'(hf0), 32'd1);
    do_reset();
    check("t4_cleared", 32'(hf0), 32'd0);

    // Reset with a pending word and 5 packed bits
    do_reset();
    stream(64'(14'b11100001010110), 14);
    check("t5_pre_valid", 32'(valid0), 32'd1);
    check("t5_pre_data", 32'(data0), 32'hE1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t5_rst_valid", 32'(valid0), 32'd0);
    check("t5_rst_data", 32'(data0), 32'd0);
    en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      raw_i = (i == 0 || i == 1 || i == 3 || i == 6 || i == 8);
      cyc();
      if (i == 7) check("t5_not_yet", 32'(valid0), 32'd0);
    end
    check("t5_post_valid", 32'(valid0), 32'd1);
    check("t5_post_data", 32'(data0), 32'h34);
    en = 1'b0;

    // en drop mid-word: partial discarded, pending word kept
    do_reset();
    stream(64'(22'b0110011010011001101001), 22);
    check("t6_w1_valid", 32'(valid1), 32'd1);
    check("t6_w1_data", 32'(data1), 32'h5A);
    stream(64'(16'h9669), 16);
    check("t6_kept_valid", 32'(valid1), 32'd1);
    check("t6_kept_data", 32'(data1), 32'h5A);
    idle(2);
    out_ready = 1'b1;
    idle(1);
    check("t6_w2_valid", 32'(valid1), 32'd1);
    check("t6_w2_data", 32'(data1), 32'h96);
    out_ready = 1'b0;
    en = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
